// File: rtl/rans_pkg.sv
// rans_pkg: shared types and default sizing for the rANS lane scheduler.
//   sched_state_e : scheduler FSM states, also exported on the debug port.
//   TABLE_SIZE    : number of frequency table entries for the default symbol width.
//   FREQ_TOTAL    : required table total for the default resolution.
//   LANE_W        : lane pointer width for the default lane count.
// Modules re-derive these from their own parameters so non-default builds stay consistent.
package rans_pkg;

  localparam int DEF_RESOLUTION   = 10;
  localparam int DEF_SYMBOL_WIDTH = 8;
  localparam int DEF_NUM_LANES    = 4;

  localparam int TABLE_SIZE = 2 ** DEF_SYMBOL_WIDTH;
  localparam int FREQ_TOTAL = 2 ** DEF_RESOLUTION;
  localparam int LANE_W     = $clog2(DEF_NUM_LANES);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CFG   = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_e;

endpackage

// File: rtl/rans_cum_freq.sv
// rans_cum_freq: running cumulative-frequency accumulator for table loading.
//   clk_i, rst_i : clock, synchronous active-high reset.
//   clear_i      : restart accumulation for a new table.
//   accept_i     : one table entry (freq_i) is consumed this cycle.
//   cum_o        : sum of all entries accepted so far (the cum_freq of the entry being accepted).
//   idx_o        : index of the entry being accepted.
//   full_o       : every table slot has been consumed.
//   table_ok_o   : if the entry being accepted were the last, the table would be valid
//                  (right entry count, exact total, no overflow at any point).
module rans_cum_freq #(
  parameter int RESOLUTION   = 10,
  parameter int SYMBOL_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    accept_i,
  input  logic [RESOLUTION-1:0]   freq_i,
  output logic [RESOLUTION-1:0]   cum_o,
  output logic [SYMBOL_WIDTH-1:0] idx_o,
  output logic                    full_o,
  output logic                    table_ok_o
);

  localparam int CW   = SYMBOL_WIDTH + 1;
  localparam int SUMW = RESOLUTION + 1;
  localparam logic [CW-1:0] N_ENTRIES_V = CW'(2 ** SYMBOL_WIDTH);
  localparam logic [SUMW:0] F_TOTAL_V   = (SUMW + 1)'(2 ** RESOLUTION);

  logic [SUMW-1:0] sum_q;
  logic            ovf_q;
  logic [CW-1:0]   count_q;

  logic [SUMW:0]   sum_ext;
  logic            ovf_nxt;
  logic [CW-1:0]   count_nxt;

  // One extra sum bit beyond the running width catches carry-out; once set the
  // overflow flag sticks so a wrapped sum can never masquerade as a valid total.
  always_comb begin
    sum_ext    = {1'b0, sum_q} + {2'b00, freq_i};
    ovf_nxt    = ovf_q | sum_ext[SUMW];
    count_nxt  = count_q + CW'(1);
    table_ok_o = (count_nxt == N_ENTRIES_V) && (sum_ext == F_TOTAL_V) && !ovf_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else if (accept_i) begin
      sum_q   <= sum_ext[SUMW-1:0];
      ovf_q   <= ovf_nxt;
      count_q <= count_nxt;
    end
  end

  assign cum_o  = sum_q[RESOLUTION-1:0];
  assign idx_o  = count_q[SYMBOL_WIDTH-1:0];
  assign full_o = (count_q == N_ENTRIES_V);

endmodule

// File: rtl/rans_lane_sched.sv
// rans_lane_sched: sequencer for an array of interleaved rANS encoder lanes.
// Loads the frequency table into every lane (with cumulative frequencies built
// on the fly), deals the symbol stream round-robin across lanes via clock
// enables, then flushes every lane once and pulses done.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset (aborts any job).
//   start_i, reuse_i        begin a job in IDLE; reuse_i skips table load if a valid table is held.
//   cfg_valid_i/cfg_ready_o table entry stream (cfg_freq_i, cfg_last_i), index 0 first.
//   s_valid_i/s_ready_o     symbol stream (s_symb_i, s_last_i).
//   hold_i                  downstream backpressure; stalls symbol dispatch and flush.
//   lane_en_o               registered per-lane enable.
//   freq_wr_o, freq_o, cum_freq_o  broadcast table write (index on symb_o).
//   symb_o                  symbol to encode, or table index during a write.
//   lane_flush_o            one-hot flush request.
//   busy_o, done_o          not-IDLE flag, one-cycle end-of-job pulse.
//   cfg_err_o               sticky table error, cleared by the next start.
//   state_o                 current scheduler state for observation.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; ready never depends on valid, and valid-without-ready transfers nothing.
module rans_lane_sched
  import rans_pkg::*;
#(
  parameter int RESOLUTION   = 10,
  parameter int SYMBOL_WIDTH = 8,
  parameter int NUM_LANES    = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    reuse_i,
  input  logic                    cfg_valid_i,
  output logic                    cfg_ready_o,
  input  logic [RESOLUTION-1:0]   cfg_freq_i,
  input  logic                    cfg_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  input  logic [SYMBOL_WIDTH-1:0] s_symb_i,
  input  logic                    s_last_i,
  input  logic                    hold_i,
  output logic [NUM_LANES-1:0]    lane_en_o,
  output logic                    freq_wr_o,
  output logic [RESOLUTION-1:0]   freq_o,
  output logic [RESOLUTION-1:0]   cum_freq_o,
  output logic [SYMBOL_WIDTH-1:0] symb_o,
  output logic [NUM_LANES-1:0]    lane_flush_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    cfg_err_o,
  output sched_state_e            state_o
);

  localparam int LW = $clog2(NUM_LANES);
  localparam logic [LW:0] LANES_V = (LW + 1)'(NUM_LANES);

  sched_state_e state_q, state_d;

  logic [LW-1:0] lane_ptr_q, lane_ptr_d;
  logic [LW:0]   flush_cnt_q, flush_cnt_d;
  logic          table_valid_q, table_valid_d;
  logic          cfg_err_q, cfg_err_d;

  logic [NUM_LANES-1:0]    lane_en_q, lane_en_d;
  logic                    freq_wr_q, freq_wr_d;
  logic [RESOLUTION-1:0]   freq_q, freq_d;
  logic [RESOLUTION-1:0]   cum_q, cum_d;
  logic [SYMBOL_WIDTH-1:0] symb_q, symb_d;
  logic [NUM_LANES-1:0]    flush_q, flush_d;

  logic [NUM_LANES-1:0]    lane_onehot;
  logic                    cf_clear;
  logic                    cf_accept;
  logic                    s_accept;
  logic [RESOLUTION-1:0]   cf_cum;
  logic [SYMBOL_WIDTH-1:0] cf_idx;
  logic                    cf_full;
  logic                    cf_ok;

  rans_cum_freq #(
    .RESOLUTION  (RESOLUTION),
    .SYMBOL_WIDTH(SYMBOL_WIDTH)
  ) u_cum_freq (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (cf_clear),
    .accept_i  (cf_accept),
    .freq_i    (cfg_freq_i),
    .cum_o     (cf_cum),
    .idx_o     (cf_idx),
    .full_o    (cf_full),
    .table_ok_o(cf_ok)
  );

  // Ready is withdrawn once the table is full so a missing cfg_last_i can't
  // wrap the entry counter; the FSM turns that cycle into an error.
  assign cfg_ready_o = (state_q == ST_CFG) && !cf_full;
  assign s_ready_o   = (state_q == ST_RUN) && !hold_i;
  assign cf_accept   = cfg_valid_i && cfg_ready_o;
  assign s_accept    = s_valid_i && s_ready_o;

  always_comb begin
    lane_onehot             = '0;
    lane_onehot[lane_ptr_q] = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    lane_ptr_d    = lane_ptr_q;
    flush_cnt_d   = flush_cnt_q;
    table_valid_d = table_valid_q;
    cfg_err_d     = cfg_err_q;
    lane_en_d     = '0;
    freq_wr_d     = 1'b0;
    freq_d        = '0;
    cum_d         = '0;
    symb_d        = '0;
    flush_d       = '0;
    cf_clear      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          cfg_err_d   = 1'b0;
          lane_ptr_d  = '0;
          flush_cnt_d = '0;
          if (reuse_i && table_valid_q) begin
            state_d = ST_RUN;
          end else begin
            // The lanes' table is about to be overwritten, so it is not
            // reusable until this load completes cleanly.
            state_d       = ST_CFG;
            table_valid_d = 1'b0;
            cf_clear      = 1'b1;
          end
        end
      end

      ST_CFG: begin
        if (cf_full) begin
          cfg_err_d     = 1'b1;
          table_valid_d = 1'b0;
          state_d       = ST_IDLE;
        end else if (cf_accept) begin
          freq_wr_d = 1'b1;
          lane_en_d = '1;
          symb_d    = cf_idx;
          freq_d    = cfg_freq_i;
          cum_d     = cf_cum;
          if (cfg_last_i) begin
            if (cf_ok) begin
              table_valid_d = 1'b1;
              state_d       = ST_RUN;
            end else begin
              cfg_err_d     = 1'b1;
              table_valid_d = 1'b0;
              state_d       = ST_IDLE;
            end
          end
        end
      end

      ST_RUN: begin
        if (s_accept) begin
          lane_en_d  = lane_onehot;
          symb_d     = s_symb_i;
          lane_ptr_d = lane_ptr_q + LW'(1);
          if (s_last_i) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = '0;
          end
        end
      end

      // The lane pointer already sits one past the last-used lane, so flushing
      // simply keeps advancing it; after NUM_LANES steps it is back where it began.
      ST_FLUSH: begin
        if (flush_cnt_q == LANES_V) begin
          state_d = ST_DONE;
        end else if (!hold_i) begin
          lane_en_d   = lane_onehot;
          flush_d     = lane_onehot;
          lane_ptr_d  = lane_ptr_q + LW'(1);
          flush_cnt_d = flush_cnt_q + (LW + 1)'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      lane_ptr_q    <= '0;
      flush_cnt_q   <= '0;
      table_valid_q <= 1'b0;
      cfg_err_q     <= 1'b0;
      lane_en_q     <= '0;
      freq_wr_q     <= 1'b0;
      freq_q        <= '0;
      cum_q         <= '0;
      symb_q        <= '0;
      flush_q       <= '0;
    end else begin
      state_q       <= state_d;
      lane_ptr_q    <= lane_ptr_d;
      flush_cnt_q   <= flush_cnt_d;
      table_valid_q <= table_valid_d;
      cfg_err_q     <= cfg_err_d;
      lane_en_q     <= lane_en_d;
      freq_wr_q     <= freq_wr_d;
      freq_q        <= freq_d;
      cum_q         <= cum_d;
      symb_q        <= symb_d;
      flush_q       <= flush_d;
    end
  end

  assign lane_en_o    = lane_en_q;
  assign freq_wr_o    = freq_wr_q;
  assign freq_o       = freq_q;
  assign cum_freq_o   = cum_q;
  assign symb_o       = symb_q;
  assign lane_flush_o = flush_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DONE);
  assign cfg_err_o    = cfg_err_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_rans_lane_sched.sv
// Self-checking bench for rans_lane_sched (RESOLUTION=10, SYMBOL_WIDTH=8, NUM_LANES=4).
module tb_rans_lane_sched;
  import rans_pkg::*;

  localparam int NL = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_i = 1'b1;
  logic         start_i = 1'b0, reuse_i = 1'b0;
  logic         cfg_valid_i = 1'b0, cfg_last_i = 1'b0;
  logic [9:0]   cfg_freq_i = '0;
  logic         s_valid_i = 1'b0, s_last_i = 1'b0, hold_i = 1'b0;
  logic [7:0]   s_symb_i = '0;

  logic         cfg_ready_o, s_ready_o, freq_wr_o, busy_o, done_o, cfg_err_o;
  logic [NL-1:0] lane_en_o, lane_flush_o;
  logic [9:0]   freq_o, cum_freq_o;
  logic [7:0]   symb_o;
  sched_state_e state_o;

  rans_lane_sched #(.RESOLUTION(10), .SYMBOL_WIDTH(8), .NUM_LANES(NL)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .reuse_i(reuse_i),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .cfg_freq_i(cfg_freq_i),
    .cfg_last_i(cfg_last_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .s_symb_i(s_symb_i), .s_last_i(s_last_i), .hold_i(hold_i),
    .lane_en_o(lane_en_o), .freq_wr_o(freq_wr_o), .freq_o(freq_o),
    .cum_freq_o(cum_freq_o), .symb_o(symb_o), .lane_flush_o(lane_flush_o),
    .busy_o(busy_o), .done_o(done_o), .cfg_err_o(cfg_err_o), .state_o(state_o)
  );

  // ---------------- scoreboard state ----------------
  int n_pass = 0;
  int n_total = 0;
  logic [9:0] exp_q[$];      // {lane, symbol} expected per dispatched symbol
  logic [9:0] tbl[256];      // table being loaded
  int job_cnt = 0;           // symbols accepted in the current job

  typedef struct {
    logic [7:0]    symb;
    logic          last;
    logic [NL-1:0] exp_en;
  } run_vec_t;
  run_vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [NL-1:0] oh(input int l);
    logic [NL-1:0] one;
    one = 1;
    return one << l;
  endfunction

  function automatic logic [63:0] all_outs();
    return {cfg_ready_o, s_ready_o, lane_en_o, freq_wr_o, freq_o, cum_freq_o,
            symb_o, lane_flush_o, busy_o, done_o, cfg_err_o};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start(input bit reuse);
    start_i = 1'b1;
    reuse_i = reuse;
    cycle();
    start_i = 1'b0;
    reuse_i = 1'b0;
    job_cnt = 0;
  endtask

  // Streams table entries 0..n-1; expected cum_freq is the prefix sum of tbl.
  task automatic feed_table(input int n, input bit send_last, input bit gaps, output int writes);
    int k;
    int cyc;
    int unsigned sum;
    bit v;
    k = 0; cyc = 0; sum = 0; writes = 0;
    while (k < n && cyc < 2000) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      cfg_valid_i = v;
      cfg_freq_i  = tbl[k];
      cfg_last_i  = send_last && (k == n - 1);
      #1 check("cfg_ready", cfg_ready_o, 1);
      cycle();
      if (v) begin
        check("cfg_write", {freq_wr_o, lane_en_o, symb_o, freq_o, cum_freq_o},
              {1'b1, {NL{1'b1}}, 8'(k), tbl[k], 10'(sum)});
        sum += tbl[k];
        k++;
      end else begin
        check("cfg_gap", freq_wr_o, 0);
      end
      writes += int'(freq_wr_o);
      cyc++;
    end
    cfg_valid_i = 1'b0;
    cfg_last_i  = 1'b0;
    check("cfg_budget", k, n);
  endtask

  // Drives n symbols; hold_mode 0=none, 1=every other cycle, 2=random.
  task automatic run_symbols(input int n, input int hold_mode, input bit rand_valid, input bit poke_start);
    int sent;
    int cyc;
    bit v, h;
    logic [7:0] sym;
    logic [9:0] e;
    sent = 0; cyc = 0;
    while (sent < n && cyc < 400) begin
      v = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      case (hold_mode)
        1:       h = (cyc % 2) == 1;
        2:       h = ($urandom_range(0, 2) == 0);
        default: h = 1'b0;
      endcase
      sym = 8'($urandom_range(0, 255));
      s_valid_i = v;
      s_symb_i  = sym;
      s_last_i  = (sent == n - 1);
      hold_i    = h;
      start_i   = poke_start && ($urandom_range(0, 3) == 0);
      reuse_i   = $urandom_range(0, 1) == 1;
      #1 check("s_ready", s_ready_o, !h);
      @(posedge clk);
      if (v && !h) begin
        exp_q.push_back({2'(job_cnt % NL), sym});
        job_cnt++;
        sent++;
      end
      @(negedge clk);
      if (lane_en_o != 0) begin
        check("en_under_hold", h, 0);
        if (exp_q.size() == 0) check("spurious_en", lane_en_o, 0);
        else begin
          e = exp_q.pop_front();
          check("run_en", {lane_en_o, symb_o}, {oh(int'(e[9:8])), e[7:0]});
        end
      end
      check("run_quiet", {lane_flush_o, freq_wr_o, done_o}, 0);
      cyc++;
    end
    s_valid_i = 1'b0; s_last_i = 1'b0; hold_i = 1'b0; start_i = 1'b0; reuse_i = 1'b0;
    check("run_budget", sent, n);
    check("run_all_dispatched", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Expects NL flushes in ascending modular order from first_lane, then done.
  task automatic flush_phase(input int first_lane, input int hold_mode);
    int issued;
    int cyc;
    bit done_seen, h;
    issued = 0; cyc = 0; done_seen = 1'b0;
    while (!done_seen && cyc < 64) begin
      case (hold_mode)
        1:       h = (cyc % 2) == 1;
        2:       h = ($urandom_range(0, 2) == 0);
        default: h = 1'b0;
      endcase
      hold_i = h;
      cycle();
      if (lane_flush_o != 0) begin
        check("flush_lane", lane_flush_o, oh((first_lane + issued) % NL));
        check("flush_en", lane_en_o, lane_flush_o);
        check("flush_under_hold", h, 0);
        issued++;
      end
      if (done_o) begin
        done_seen = 1'b1;
        check("flush_count_at_done", issued, NL);
      end
      cyc++;
    end
    hold_i = 1'b0;
    check("done_seen", done_seen, 1);
    cycle();
    check("idle_after_done", {busy_o, done_o, state_o}, {1'b0, 1'b0, ST_IDLE});
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int w;
    bit any_done;
    int idx;

    vecs = '{'{8'h00, 1'b0, 4'h1}, '{8'h01, 1'b0, 4'h2}, '{8'h02, 1'b0, 4'h4},
             '{8'h03, 1'b0, 4'h8}, '{8'h04, 1'b0, 4'h1}, '{8'h05, 1'b0, 4'h2},
             '{8'h06, 1'b0, 4'h4}, '{8'h07, 1'b0, 4'h8}, '{8'h08, 1'b0, 4'h1},
             '{8'h09, 1'b1, 4'h2}};

    // Reset
    @(negedge clk);
    cycle(); cycle();
    check("reset_outs", all_outs(), 0);
    rst_i = 1'b0;
    cycle();
    check("post_reset_outs", all_outs(), 0);
    check("post_reset_state", state_o, ST_IDLE);

    // reuse without a valid table falls back to CFG; uniform table of 4s
    do_start(1'b1);
    check("fallback_cfg", {state_o, busy_o}, {ST_CFG, 1'b1});
    for (int i = 0; i < 256; i++) tbl[i] = 10'd4;
    feed_table(256, 1'b1, 1'b0, w);
    check("uniform_writes", w, 256);
    check("uniform_state", {state_o, cfg_err_o}, {ST_RUN, 1'b0});

    // Ten symbols, no hold, table-driven
    for (int i = 0; i < 10; i++) begin
      s_valid_i = 1'b1;
      s_symb_i  = vecs[i].symb;
      s_last_i  = vecs[i].last;
      cycle();
      check("vec_en", lane_en_o, vecs[i].exp_en);
      check("vec_symb", symb_o, vecs[i].symb);
    end
    s_valid_i = 1'b0; s_last_i = 1'b0;
    flush_phase(2, 0);

    // Reused table, hold toggling every other cycle
    do_start(1'b1);
    check("reuse_run", {state_o, freq_wr_o}, {ST_RUN, 1'b0});
    run_symbols(6, 1, 1'b0, 1'b0);
    flush_phase(job_cnt % NL, 1);

    // Randomized job with random valid/hold and ignored start pulses
    do_start(1'b1);
    check("reuse_run2", state_o, ST_RUN);
    run_symbols(23, 2, 1'b1, 1'b1);
    flush_phase(job_cnt % NL, 2);

    // Random table summing to 1024, with zero entries and valid gaps
    for (int i = 0; i < 256; i++) tbl[i] = 10'd0;
    for (int u = 0; u < 1024; u++) begin
      idx = $urandom_range(0, 255);
      tbl[idx] = tbl[idx] + 10'd1;
    end
    do_start(1'b0);
    feed_table(256, 1'b1, 1'b1, w);
    check("rand_tbl_state", {state_o, cfg_err_o}, {ST_RUN, 1'b0});
    run_symbols(9, 2, 1'b1, 1'b0);
    flush_phase(job_cnt % NL, 0);

    // Bad table: sums to 1020
    for (int i = 0; i < 256; i++) tbl[i] = 10'd4;
    tbl[255] = 10'd0;
    do_start(1'b0);
    feed_table(256, 1'b1, 1'b0, w);
    check("bad_tbl_state", {state_o, busy_o, cfg_err_o}, {ST_IDLE, 1'b0, 1'b1});
    any_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      any_done |= done_o;
    end
    check("bad_tbl_no_done", any_done, 0);
    check("bad_tbl_err_sticky", cfg_err_o, 1);
    do_start(1'b1);
    check("bad_tbl_reuse_cfg", {state_o, cfg_err_o}, {ST_CFG, 1'b0});

    // Reset in the middle of CFG at entry 100
    feed_table(100, 1'b0, 1'b0, w);
    cfg_valid_i = 1'b1;
    cfg_freq_i  = tbl[100];
    rst_i       = 1'b1;
    cycle();
    check("mid_cfg_reset_outs", all_outs(), 0);
    check("mid_cfg_reset_state", state_o, ST_IDLE);
    cfg_valid_i = 1'b0;
    rst_i       = 1'b0;
    cycle();
    do_start(1'b1);
    check("after_reset_cfg", state_o, ST_CFG);

    // 256 entries without cfg_last_i
    feed_table(256, 1'b0, 1'b0, w);
    check("overrun_writes", w, 256);
    cfg_valid_i = 1'b1;
    #1 check("overrun_ready_low", cfg_ready_o, 0);
    cycle();
    cfg_valid_i = 1'b0;
    check("overrun_err", {state_o, cfg_err_o, freq_wr_o, done_o}, {ST_IDLE, 1'b1, 1'b0, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rans_lane_sched.md
Name: rans_lane_sched

Overview:
Sequencer for the array of interleaved rANS encoder lanes. It loads the frequency table into all lanes and computes cumulative frequencies on the fly. It then dispatches the incoming symbol stream round-robin, one symbol per lane enable, and finishes with a per-lane flush sequence. It sits between the host-facing symbol/config streams and the per-lane `rans` instances, which it drives through clock enables rather than gated clocks.

Parameters:
- RESOLUTION, 10, frequency precision in bits; table total must equal 2^RESOLUTION.
- SYMBOL_WIDTH, 8, symbol width; the table holds 2^SYMBOL_WIDTH entries.
- NUM_LANES, 4, number of encoder lanes; power of two, ≥2.

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  begin a job; sampled in IDLE only.
- reuse_i  in  1  with start_i: skip CFG and reuse the loaded table.
- cfg_valid_i  in  1  frequency entry valid.
- cfg_ready_o  out  1  entry accepted when valid&ready.
- cfg_freq_i  in  RESOLUTION  frequency of the next symbol index (index 0 first).
- cfg_last_i  in  1  marks the final table entry.
- s_valid_i  in  1  symbol valid.
- s_ready_o  out  1  symbol accepted when valid&ready.
- s_symb_i  in  SYMBOL_WIDTH  symbol.
- s_last_i  in  1  final symbol of the job.
- hold_i  in  1  downstream backpressure; stalls dispatch.
- lane_en_o  out  NUM_LANES  per-lane enable, registered.
- freq_wr_o  out  1  table write strobe, broadcast.
- freq_o  out  RESOLUTION  frequency to write.
- cum_freq_o  out  RESOLUTION  cumulative frequency to write.
- symb_o  out  SYMBOL_WIDTH  symbol to encode, or table index during a write.
- lane_flush_o  out  NUM_LANES  one-hot flush request.
- busy_o  out  1  high in any state except IDLE.
- done_o  out  1  one-cycle pulse at job end.
- cfg_err_o  out  1  sticky table error; cleared by the next start_i.

Behaviour:
- Reset:
  - All outputs 0; state IDLE.
  - Lane pointer 0, running sum 0, entry counter 0.
  - table_valid flag cleared.
- States: IDLE, CFG, RUN, FLUSH, DONE.
- IDLE:
  - start_i & reuse_i & table_valid → RUN.
  - start_i otherwise → CFG. reuse_i without table_valid falls back to CFG.
  - cfg_err_o clears on start_i.
- CFG:
  - cfg_ready_o = 1.
  - On each accepted entry k, the next cycle drives: freq_wr_o = 1, lane_en_o = all ones, symb_o = k, freq_o = cfg_freq_i, cum_freq_o = sum of entries 0..k-1. Latency is 1 cycle.
  - Running sum is RESOLUTION+1 bits plus a sticky overflow bit. Zero frequencies are legal and still written.
  - On the accepted cfg_last_i entry, check count == 2^SYMBOL_WIDTH, final sum == 2^RESOLUTION, and no overflow.
    - Pass: set table_valid, go to RUN.
    - Fail: set cfg_err_o, clear table_valid, go to IDLE with no done_o.
  - 2^SYMBOL_WIDTH entries accepted without cfg_last_i: treat the next cycle as an error and go to IDLE.
- RUN:
  - s_ready_o = !hold_i.
  - A symbol accepted at cycle t produces, at t+1, lane_en_o one-hot at the lane pointer and symb_o = symbol. The pointer then increments modulo NUM_LANES.
  - No accept → lane_en_o = 0, so lanes hold state.
  - The lane pointer persists across symbols in a job. It resets to 0 at each start_i.
  - Accepted s_last_i → FLUSH, after that symbol's enable cycle.
- FLUSH:
  - Starting from the lane after the last-used lane, assert lane_flush_o and lane_en_o one-hot for one cycle per lane. Visit all NUM_LANES lanes in ascending modular order.
  - hold_i pauses the sequence; the current lane stays low until release.
  - After the last lane → DONE.
- DONE: done_o = 1 for one cycle, then IDLE.
- Inputs out of phase are ignored:
  - cfg_valid_i outside CFG (cfg_ready_o = 0).
  - s_valid_i outside RUN (s_ready_o = 0).
  - start_i while busy.
- Same-cycle events:
  - hold_i and s_valid_i together: no accept, and the pointer does not advance.
  - s_last_i on an otherwise normal accept follows the same timing as any other symbol.
- rst_i mid-job aborts immediately. Outputs are 0 on the next cycle, and the table must be reloaded.

Decomposition:
- Package rans_pkg holds:
  - state enum sched_state_e;
  - localparams TABLE_SIZE = 2**SYMBOL_WIDTH, FREQ_TOTAL = 2**RESOLUTION, LANE_W = $clog2(NUM_LANES).
- One sub-module, rans_cum_freq: running-sum, count and validation logic for CFG.

Test Plan:
- Uniform table, 256 entries of freq 4 → 256 freq_wr_o pulses; entry k has cum_freq_o = 4k; state goes to RUN; cfg_err_o = 0.
- Table summing to 1020, last entry 0 → cfg_err_o = 1, return to IDLE, no done_o; a following start_i with reuse_i = 1 enters CFG.
- RUN with 10 symbols 0x00..0x09, no hold → lane_en_o sequence 1,2,4,8,1,2,4,8,1,2; flush order lanes 2,3,0,1; done_o after the final flush.
- hold_i toggled every other cycle for 6 symbols → no enable while hold_i is high; lane order unbroken; no symbol lost or duplicated.
- Second job with reuse_i = 1 → no freq_wr_o; first symbol goes to lane 0.
- rst_i asserted mid-CFG at entry 100 → all outputs 0 next cycle; start_i & reuse_i enters CFG.
